// File: rtl/axil_regfile_responder.sv
// axil_regfile_responder: AXI4-Lite slave that fronts a bank of 32-bit
// control registers. Write address and write data are buffered separately,
// so they may arrive in either order. Register contents go out on a flat
// bus, and each committed write raises a one-cycle pulse for its register.
// Reset is synchronous and active-low.
module axil_regfile_responder #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_awaddr,
  input  logic [2:0]                    S_AXI_awprot,
  input  logic                          S_AXI_awvalid,
  output logic                          S_AXI_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_wstrb,
  input  logic                          S_AXI_wvalid,
  output logic                          S_AXI_wready,
  output logic [1:0]                    S_AXI_bresp,
  output logic                          S_AXI_bvalid,
  input  logic                          S_AXI_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_araddr,
  input  logic [2:0]                    S_AXI_arprot,
  input  logic                          S_AXI_arvalid,
  output logic                          S_AXI_arready,
  output logic [AXI_DATA_WIDTH-1:0]     S_AXI_rdata,
  output logic [1:0]                    S_AXI_rresp,
  output logic                          S_AXI_rvalid,
  input  logic                          S_AXI_rready,
  output logic [NUM_REGS*32-1:0]        regs_o,
  output logic [NUM_REGS-1:0]           wr_pulse_o
);

  // Only a 32-bit data path is supported; the register width follows it.
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = AXI_ADDR_WIDTH - 2;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] REG_LIMIT = IDX_W'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write-side state
  logic                      aw_held_reg;
  logic [IDX_W-1:0]          aw_idx_reg;
  logic                      w_held_reg;
  logic [AXI_DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_W-1:0]         w_strb_reg;
  logic                      bvalid_reg;
  logic [1:0]                bresp_reg;
  logic [NUM_REGS-1:0]       wr_pulse_reg;

  // Read-side state
  logic                      rvalid_reg;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]                rresp_reg;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic                      commit;
  logic [IDX_W-1:0]          wr_idx;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]         wr_strb;
  logic                      wr_in_range;
  logic [IDX_W-1:0]          rd_idx;
  logic                      rd_in_range;
  logic [SEL_W-1:0]          rd_sel;
  logic [NUM_REGS-1:0]       reg_sel;
  logic [AXI_DATA_WIDTH-1:0] reg_view [NUM_REGS];

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr[1:0], S_AXI_araddr[1:0]};

  // Readies drop during reset and while a response is pending or a slot is full.
  assign S_AXI_awready = rst & ~aw_held_reg & ~bvalid_reg;
  assign S_AXI_wready  = rst & ~w_held_reg & ~bvalid_reg;
  assign S_AXI_arready = rst & ~rvalid_reg;

  assign aw_hs = S_AXI_awvalid & S_AXI_awready;
  assign w_hs  = S_AXI_wvalid & S_AXI_wready;
  assign ar_hs = S_AXI_arvalid & S_AXI_arready;

  // A held beat takes precedence; otherwise the beat on the bus this cycle is used.
  assign wr_idx  = aw_held_reg ? aw_idx_reg : S_AXI_awaddr[AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held_reg ? w_data_reg : S_AXI_wdata;
  assign wr_strb = w_held_reg ? w_strb_reg : S_AXI_wstrb;
  assign commit  = (aw_held_reg | aw_hs) & (w_held_reg | w_hs) & ~bvalid_reg;
  assign wr_in_range = (wr_idx < REG_LIMIT);

  assign rd_idx      = S_AXI_araddr[AXI_ADDR_WIDTH-1:2];
  assign rd_in_range = (rd_idx < REG_LIMIT);
  assign rd_sel      = rd_idx[SEL_W-1:0];

  assign S_AXI_bvalid = bvalid_reg;
  assign S_AXI_bresp  = bresp_reg;
  assign S_AXI_rvalid = rvalid_reg;
  assign S_AXI_rdata  = rdata_reg;
  assign S_AXI_rresp  = rresp_reg;
  assign wr_pulse_o   = wr_pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [AXI_DATA_WIDTH-1:0] value_reg;

      assign reg_sel[gi] = commit & wr_in_range & (wr_idx == IDX_W'(gi));
      assign regs_o[32*gi +: 32] = value_reg;
      assign reg_view[gi] = value_reg;

      // Byte-wise update of this register on a committed in-range write.
      always_ff @(posedge clk) begin
        if (!rst) begin
          value_reg <= '0;
        end else if (reg_sel[gi]) begin
          for (int j = 0; j < STRB_W; j++) begin
            if (wr_strb[j]) begin
              value_reg[8*j +: 8] <= wr_data[8*j +: 8];
            end
          end
        end
      end
    end
  endgenerate

  // Write channel: buffer AW and W independently, commit once both are present.
  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_held_reg  <= 1'b0;
      aw_idx_reg   <= '0;
      w_held_reg   <= 1'b0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      wr_pulse_reg <= '0;
    end else begin
      // The pulse vector is already zero for an out-of-range or absent commit.
      wr_pulse_reg <= reg_sel;
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_idx_reg  <= S_AXI_awaddr[AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        w_data_reg <= S_AXI_wdata;
        w_strb_reg <= S_AXI_wstrb;
      end
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_reg && S_AXI_bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  // Read channel: capture data on AR handshake and hold it until R is taken.
  // Register values are sampled before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_in_range ? reg_view[rd_sel] : '0;
      rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_reg && S_AXI_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_regfile_responder.sv
// Directed testbench for axil_regfile_responder (NUM_REGS = 16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axil_regfile_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  S_AXI_awaddr;
  logic [2:0]   S_AXI_awprot;
  logic         S_AXI_awvalid;
  logic         S_AXI_awready;
  logic [31:0]  S_AXI_wdata;
  logic [3:0]   S_AXI_wstrb;
  logic         S_AXI_wvalid;
  logic         S_AXI_wready;
  logic [1:0]   S_AXI_bresp;
  logic         S_AXI_bvalid;
  logic         S_AXI_bready;
  logic [31:0]  S_AXI_araddr;
  logic [2:0]   S_AXI_arprot;
  logic         S_AXI_arvalid;
  logic         S_AXI_arready;
  logic [31:0]  S_AXI_rdata;
  logic [1:0]   S_AXI_rresp;
  logic         S_AXI_rvalid;
  logic         S_AXI_rready;
  logic [511:0] regs_o;
  logic [15:0]  wr_pulse_o;

  logic [511:0] exp_regs;
  int tests_run = 0;
  int fails = 0;

  axil_regfile_responder #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .NUM_REGS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
    .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
    .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (S_AXI_awready !== 1'b0) begin fails++; $display("FAIL rst_awready: got %b expected 0", S_AXI_awready); end
    tests_run++; if (S_AXI_wready !== 1'b0) begin fails++; $display("FAIL rst_wready: got %b expected 0", S_AXI_wready); end
    tests_run++; if (S_AXI_arready !== 1'b0) begin fails++; $display("FAIL rst_arready: got %b expected 0", S_AXI_arready); end
    tests_run++; if ({S_AXI_bvalid, S_AXI_bresp, S_AXI_rvalid, S_AXI_rresp} !== 6'd0) begin fails++; $display("FAIL rst_resp: got %b expected 0", {S_AXI_bvalid, S_AXI_bresp, S_AXI_rvalid, S_AXI_rresp}); end
    tests_run++; if (S_AXI_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h expected 0", S_AXI_rdata); end
    tests_run++; if (wr_pulse_o !== 16'h0) begin fails++; $display("FAIL rst_pulse: got %h expected 0", wr_pulse_o); end
    tests_run++; if (regs_o !== 512'h0) begin fails++; $display("FAIL rst_regs: got nonzero expected 0"); end
    rst = 1'b1;
    #1;
    tests_run++; if ({S_AXI_awready, S_AXI_wready, S_AXI_arready} !== 3'b111) begin fails++; $display("FAIL rst_release_ready: got %b expected 111", {S_AXI_awready, S_AXI_wready, S_AXI_arready}); end
    $display("[TB] reset: held 3 cycles, released");
  endtask

  task automatic test_aligned();
    @(negedge clk);
    S_AXI_awaddr = 32'h08; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = 32'hDEADBEEF; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    exp_regs[64 +: 32] = 32'hDEADBEEF;
    tests_run++; if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== 2'b00) begin fails++; $display("FAIL aligned_b: got bvalid=%b bresp=%b expected 1/00", S_AXI_bvalid, S_AXI_bresp); end
    tests_run++; if (wr_pulse_o !== 16'h0004) begin fails++; $display("FAIL aligned_pulse: got %h expected 0004", wr_pulse_o); end
    tests_run++; if (regs_o !== exp_regs) begin fails++; $display("FAIL aligned_reg2: got %h expected %h", regs_o[64 +: 32], exp_regs[64 +: 32]); end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    tests_run++; if (S_AXI_bvalid !== 1'b0 || wr_pulse_o !== 16'h0) begin fails++; $display("FAIL aligned_bclear: got bvalid=%b pulse=%h expected 0/0000", S_AXI_bvalid, wr_pulse_o); end
    $display("[TB] write addr=08 data=deadbeef strb=f");
    S_AXI_araddr = 32'h08; S_AXI_arvalid = 1'b1;
    @(negedge clk);
    S_AXI_arvalid = 1'b0;
    tests_run++; if (S_AXI_rvalid !== 1'b1 || S_AXI_rresp !== 2'b00 || S_AXI_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL aligned_read: got rvalid=%b rresp=%b rdata=%h expected 1/00/deadbeef", S_AXI_rvalid, S_AXI_rresp, S_AXI_rdata); end
    S_AXI_rready = 1'b1;
    @(negedge clk);
    S_AXI_rready = 1'b0;
    tests_run++; if (S_AXI_rvalid !== 1'b0) begin fails++; $display("FAIL aligned_rclear: got %b expected 0", S_AXI_rvalid); end
    $display("[TB] read addr=08 data=%h", S_AXI_rdata);
  endtask

  task automatic test_partial_w_first();
    S_AXI_wdata = 32'h11223344; S_AXI_wstrb = 4'b0101; S_AXI_wvalid = 1'b1;
    @(negedge clk);
    S_AXI_wvalid = 1'b0;
    tests_run++; if (S_AXI_wready !== 1'b0) begin fails++; $display("FAIL partial_wready_held: got %b expected 0", S_AXI_wready); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (S_AXI_bvalid !== 1'b0) begin fails++; $display("FAIL partial_early_bvalid: got %b expected 0 (cycle %0d)", S_AXI_bvalid, i); end
      if (i < 2) @(negedge clk);
    end
    S_AXI_awaddr = 32'h08; S_AXI_awvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0;
    exp_regs[64 +: 32] = 32'hDE22BE44;
    tests_run++; if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== 2'b00) begin fails++; $display("FAIL partial_b: got bvalid=%b bresp=%b expected 1/00", S_AXI_bvalid, S_AXI_bresp); end
    tests_run++; if (regs_o !== exp_regs) begin fails++; $display("FAIL partial_reg2: got %h expected %h", regs_o[64 +: 32], exp_regs[64 +: 32]); end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    $display("[TB] write addr=08 data=11223344 strb=5 (W first)");
  endtask

  task automatic test_zero_strobe();
    S_AXI_awaddr = 32'h04; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = 32'hFFFFFFFF; S_AXI_wstrb = 4'h0; S_AXI_wvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    tests_run++; if (wr_pulse_o !== 16'h0002) begin fails++; $display("FAIL zstrb_pulse: got %h expected 0002", wr_pulse_o); end
    tests_run++; if (regs_o !== exp_regs) begin fails++; $display("FAIL zstrb_regs: got reg1=%h expected %h", regs_o[32 +: 32], exp_regs[32 +: 32]); end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    $display("[TB] write addr=04 strb=0");
  endtask

  task automatic test_out_of_range();
    S_AXI_awaddr = 32'h40; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = 32'hFFFFFFFF; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    tests_run++; if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== 2'b10) begin fails++; $display("FAIL oor_b: got bvalid=%b bresp=%b expected 1/10", S_AXI_bvalid, S_AXI_bresp); end
    tests_run++; if (wr_pulse_o !== 16'h0) begin fails++; $display("FAIL oor_pulse: got %h expected 0000", wr_pulse_o); end
    tests_run++; if (regs_o !== exp_regs) begin fails++; $display("FAIL oor_regs: register bank changed on out-of-range write"); end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    $display("[TB] write addr=40 bresp=%b", S_AXI_bresp);
    S_AXI_araddr = 32'h40; S_AXI_arvalid = 1'b1;
    @(negedge clk);
    S_AXI_arvalid = 1'b0;
    tests_run++; if (S_AXI_rvalid !== 1'b1 || S_AXI_rresp !== 2'b10 || S_AXI_rdata !== 32'h0) begin fails++; $display("FAIL oor_read: got rvalid=%b rresp=%b rdata=%h expected 1/10/00000000", S_AXI_rvalid, S_AXI_rresp, S_AXI_rdata); end
    S_AXI_rready = 1'b1;
    @(negedge clk);
    S_AXI_rready = 1'b0;
    $display("[TB] read addr=40 rresp=10");
  endtask

  task automatic test_backpressure();
    S_AXI_awaddr = 32'h14; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = 32'hCAFEF00D; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    exp_regs[160 +: 32] = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (S_AXI_bvalid !== 1'b1 || S_AXI_bresp !== 2'b00 || S_AXI_awready !== 1'b0 || S_AXI_wready !== 1'b0) begin fails++; $display("FAIL bp_b: got bvalid=%b bresp=%b awready=%b wready=%b expected 1/00/0/0", S_AXI_bvalid, S_AXI_bresp, S_AXI_awready, S_AXI_wready); end
      @(negedge clk);
    end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    tests_run++; if (S_AXI_bvalid !== 1'b0 || S_AXI_awready !== 1'b1) begin fails++; $display("FAIL bp_brelease: got bvalid=%b awready=%b expected 0/1", S_AXI_bvalid, S_AXI_awready); end
    $display("[TB] write addr=14 data=cafef00d (5 cycles B stall)");
    S_AXI_araddr = 32'h14; S_AXI_arvalid = 1'b1;
    @(negedge clk);
    S_AXI_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (S_AXI_rvalid !== 1'b1 || S_AXI_rdata !== 32'hCAFEF00D || S_AXI_arready !== 1'b0) begin fails++; $display("FAIL bp_r: got rvalid=%b rdata=%h arready=%b expected 1/cafef00d/0", S_AXI_rvalid, S_AXI_rdata, S_AXI_arready); end
      @(negedge clk);
    end
    S_AXI_rready = 1'b1;
    @(negedge clk);
    S_AXI_rready = 1'b0;
    tests_run++; if (S_AXI_rvalid !== 1'b0 || S_AXI_arready !== 1'b1) begin fails++; $display("FAIL bp_rrelease: got rvalid=%b arready=%b expected 0/1", S_AXI_rvalid, S_AXI_arready); end
    $display("[TB] read addr=14 data=cafef00d (5 cycles R stall)");
  endtask

  task automatic test_collision();
    S_AXI_awaddr = 32'h0C; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = 32'h12345678; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    exp_regs[96 +: 32] = 32'h12345678;
    S_AXI_awaddr = 32'h0C; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = 32'hA5A5A5A5; S_AXI_wvalid = 1'b1;
    S_AXI_araddr = 32'h0C; S_AXI_arvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0;
    tests_run++; if (S_AXI_rvalid !== 1'b1 || S_AXI_rdata !== 32'h12345678) begin fails++; $display("FAIL collide_read: got rvalid=%b rdata=%h expected 1/12345678", S_AXI_rvalid, S_AXI_rdata); end
    exp_regs[96 +: 32] = 32'hA5A5A5A5;
    tests_run++; if (regs_o !== exp_regs) begin fails++; $display("FAIL collide_reg3: got %h expected %h", regs_o[96 +: 32], exp_regs[96 +: 32]); end
    S_AXI_bready = 1'b1; S_AXI_rready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0; S_AXI_rready = 1'b0;
    $display("[TB] collide write/read addr=0c old=12345678 new=a5a5a5a5");
  endtask

  task automatic test_reset_mid();
    S_AXI_awaddr = 32'h0C; S_AXI_awvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0;
    tests_run++; if (S_AXI_awready !== 1'b0 || S_AXI_bvalid !== 1'b0) begin fails++; $display("FAIL mid_held: got awready=%b bvalid=%b expected 0/0", S_AXI_awready, S_AXI_bvalid); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_regs = '0;
    tests_run++; if (S_AXI_bvalid !== 1'b0 || regs_o !== exp_regs) begin fails++; $display("FAIL mid_reset: got bvalid=%b reg3=%h expected 0/00000000", S_AXI_bvalid, regs_o[96 +: 32]); end
    // The discarded AW must not pair with a fresh W beat.
    S_AXI_wdata = 32'h00000077; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    @(negedge clk);
    S_AXI_wvalid = 1'b0;
    @(negedge clk);
    tests_run++; if (S_AXI_bvalid !== 1'b0 || regs_o !== exp_regs) begin fails++; $display("FAIL mid_no_resp: got bvalid=%b reg3=%h expected 0/00000000", S_AXI_bvalid, regs_o[96 +: 32]); end
    S_AXI_awaddr = 32'h0C; S_AXI_awvalid = 1'b1;
    @(negedge clk);
    S_AXI_awvalid = 1'b0;
    exp_regs[96 +: 32] = 32'h00000077;
    tests_run++; if (S_AXI_bvalid !== 1'b1 || regs_o !== exp_regs) begin fails++; $display("FAIL mid_recover: got bvalid=%b reg3=%h expected 1/00000077", S_AXI_bvalid, regs_o[96 +: 32]); end
    S_AXI_bready = 1'b1;
    @(negedge clk);
    S_AXI_bready = 1'b0;
    $display("[TB] reset with AW held, then write addr=0c data=00000077");
  endtask

  initial begin
    rst = 1'b0;
    S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wvalid = 1'b0;
    S_AXI_bready = 1'b0;
    S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_arvalid = 1'b0;
    S_AXI_rready = 1'b0;
    exp_regs = '0;
    test_reset();
    test_aligned();
    test_partial_w_first();
    test_zero_strobe();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
